// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller.
// FSM encodings and tag-width derivation.
package cache_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_MEM_RD = 2'd2;
  localparam logic [1:0] S_MEM_WR = 2'd3;

  localparam int ADDR_W_DFLT  = 32;
  localparam int INDEX_W_DFLT = 6;
  localparam int TAG_W        = ADDR_W_DFLT - INDEX_W_DFLT;

  function automatic int tag_w(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/cache_ctrl_dataram.sv
// Single-port data store with registered read.
// A write and a read of the same address return the old word.
module DataRam #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] DataOut
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (We) mem[Addr] <= WData;
    DataOut <= mem[Addr];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
// Tag and valid arrays live here; data words live in DataRam.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CpuReq,
  input  logic              CpuWrite,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuDone,
  output logic              CpuBusy,
  input  logic              Flush,
  output logic              MemReq,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData,
  output logic [15:0]       HitCount,
  output logic [15:0]       MissCount
);

  localparam int TW    = tag_w(ADDR_W, INDEX_W);
  localparam int LINES = 2**INDEX_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_mem [LINES];
  logic [TW-1:0]     tag_rd_q;

  logic [INDEX_W-1:0] idx_q, ram_addr;
  logic [TW-1:0]      tag_q;
  logic [DATA_W-1:0]  ram_dout, ram_wdata, rdata;
  logic               ram_we, tag_we, hit;
  logic               hit_inc, miss_inc;

  assign idx_q    = addr_q[INDEX_W-1:0];
  assign tag_q    = addr_q[ADDR_W-1:INDEX_W];
  assign ram_addr = (state_q == S_IDLE) ? CpuAddr[INDEX_W-1:0] : idx_q;
  assign hit      = valid_q[idx_q] && (tag_rd_q == tag_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    valid_d   = valid_q;
    ram_we    = 1'b0;
    ram_wdata = wdata_q;
    tag_we    = 1'b0;
    CpuDone   = 1'b0;
    rdata     = '0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Flush) begin
          valid_d = '0;
        end else if (CpuReq) begin
          addr_d  = CpuAddr;
          wdata_d = CpuWData;
          write_d = CpuWrite;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_inc  = hit;
        miss_inc = !hit;
        if (write_q) begin
          ram_we  = hit;
          state_d = S_MEM_WR;
        end else if (hit) begin
          CpuDone = 1'b1;
          rdata   = ram_dout;
          state_d = S_IDLE;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (MemAck) begin
          ram_we         = 1'b1;
          ram_wdata      = MemRData;
          tag_we         = 1'b1;
          valid_d[idx_q] = 1'b1;
          CpuDone        = 1'b1;
          rdata          = MemRData;
          state_d        = S_IDLE;
        end
      end
      S_MEM_WR: begin
        if (MemAck) begin
          CpuDone = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
    if (miss_inc && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tags are not reset; a reset mid-fill must still suppress the write.
  always_ff @(posedge Clk) begin
    if (tag_we && !Rst) tag_mem[idx_q] <= tag_q;
    tag_rd_q <= tag_mem[ram_addr];
  end

  DataRam #(
    .ADDR_W(INDEX_W),
    .DATA_W(DATA_W)
  ) u_data_ram (
    .Clk    (Clk),
    .We     (ram_we && !Rst),
    .Addr   (ram_addr),
    .WData  (ram_wdata),
    .DataOut(ram_dout)
  );

  assign CpuRData  = rdata;
  assign CpuBusy   = (state_q != S_IDLE);
  assign MemReq    = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign MemWrite  = (state_q == S_MEM_WR);
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule
